// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared run-control state encoding and default widths for the fetch stage
package fetch_unit_pkg;
  localparam int PC_W_DEF = 12;
  localparam int ROM_W_DEF = 8;
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter register with load, increment and hold, async reset
module pc_counter import fetch_unit_pkg::*; #(
  parameter int W = PC_W_DEF,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk2,
  input  logic         reset2,
  input  logic         load,
  input  logic         inc,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // hold freezes the count; load beats inc; increment wraps silently
  always_ff @(posedge clk2 or posedge reset2)
    if (reset2) q <= RST;
    else if (!hold) q <= load ? d : inc ? q + 1'b1 : q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and RUN/HALT/STEP run control gating the Phase enable
// Optional breakpoint comparator and bkpt_addr port are built when FETCH_BKPT_EN is defined.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int PC_W = PC_W_DEF,
  parameter int ROM_W = ROM_W_DEF,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic             clk2,
  input  logic             reset2,
  input  logic             phase,
  input  logic             inc_pc,
  input  logic             load_pc,
  input  logic [ROM_W-1:0] rom_data,
  input  logic             halt_req,
  input  logic             run_req,
  input  logic             step_req,
`ifdef FETCH_BKPT_EN
  input  logic [PC_W-1:0]  bkpt_addr,
`endif
  output logic [PC_W-1:0]  rom_addr,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       instr,
  output logic [3:0]       oprnd,
  output logic             phase_en,
  output logic             halted
);
  state_t state;
  logic [ROM_W-1:0] ir;
  logic halt_pend;
  logic frozen;
  logic [PC_W-1:0] target;
  assign frozen = state == ST_HALT;
  assign target = PC_W'({ir[3:0], rom_data});
  assign rom_addr = pc;
  assign instr = ir[ROM_W-1 -: 4];
  assign oprnd = ir[3:0];
  assign phase_en = !frozen;
  assign halted = frozen;
  pc_counter #(.W(PC_W), .RST(RST_PC)) u_pc (
    .clk2  (clk2),
    .reset2(reset2),
    .load  (load_pc),
    .inc   (inc_pc),
    .hold  (frozen),
    .d     (target),
    .q     (pc)
  );
`ifdef FETCH_BKPT_EN
  logic bkpt_hit;
  logic bkpt_skip;
  logic [PC_W-1:0] pc_next;
  assign pc_next = load_pc ? target : inc_pc ? pc + 1'b1 : pc;
`endif
  // instruction register captures the ROM byte on each unfrozen fetch edge
  always_ff @(posedge clk2 or posedge reset2)
    if (reset2) ir <= '0;
    else if (!phase && !frozen) ir <= rom_data;
  // run control: halts only at instruction boundaries (execute edges)
  always_ff @(posedge clk2 or posedge reset2)
    if (reset2) begin
      state <= ST_RUN;
      halt_pend <= 1'b0;
`ifdef FETCH_BKPT_EN
      bkpt_hit <= 1'b0;
      bkpt_skip <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          halt_pend <= (halt_req | halt_pend) & !phase;
          if (phase && (halt_req || halt_pend)) state <= ST_HALT;
`ifdef FETCH_BKPT_EN
          else if (phase && !bkpt_skip && pc_next == bkpt_addr) begin
            state <= ST_HALT;
            bkpt_hit <= 1'b1;
          end
          if (phase) bkpt_skip <= 1'b0;
`endif
        end
        ST_HALT: begin
          state <= run_req ? ST_RUN : step_req ? ST_STEP : ST_HALT;
`ifdef FETCH_BKPT_EN
          if (run_req || step_req) begin
            bkpt_hit <= 1'b0;
            bkpt_skip <= 1'b1;
          end
`endif
        end
        ST_STEP: begin
          if (phase) state <= ST_HALT;
`ifdef FETCH_BKPT_EN
          if (phase) bkpt_skip <= 1'b0;
`endif
        end
        default: state <= ST_RUN;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table and sequence checks of fetch_unit with a Phase flop model
module tb_fetch_unit;
  logic clk2 = 1'b0;
  logic reset2 = 1'b1;
  logic phase;
  logic inc_man = 1'b0;
  logic auto_inc = 1'b0;
  logic load_pc = 1'b0;
  logic halt_req = 1'b0;
  logic run_req = 1'b0;
  logic step_req = 1'b0;
  logic inc_pc;
  logic ovr_en = 1'b0;
  logic [7:0] ovr = 8'h00;
  logic [7:0] rom [4096];
  logic [7:0] rom_data;
  logic [11:0] rom_addr;
  logic [11:0] pc;
  logic [11:0] bkpt_addr = 12'hABC;
  logic [3:0] instr;
  logic [3:0] oprnd;
  logic phase_en;
  logic halted;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic inc;
    logic load;
    logic use_ovr;
    logic [7:0] ovr_byte;
    logic [7:0] exp_ir;
    logic [11:0] exp_pc;
  } vec_t;
  vec_t tbl[10];
  logic [11:0] cur_pc;
  fetch_unit dut (
    .clk2     (clk2),
    .reset2   (reset2),
    .phase    (phase),
    .inc_pc   (inc_pc),
    .load_pc  (load_pc),
    .rom_data (rom_data),
    .halt_req (halt_req),
    .run_req  (run_req),
    .step_req (step_req),
`ifdef FETCH_BKPT_EN
    .bkpt_addr(bkpt_addr),
`endif
    .rom_addr (rom_addr),
    .pc       (pc),
    .instr    (instr),
    .oprnd    (oprnd),
    .phase_en (phase_en),
    .halted   (halted)
  );
  always #5 clk2 = ~clk2;
  always_ff @(posedge clk2 or posedge reset2)
    if (reset2) phase <= 1'b0;
    else if (phase_en) phase <= ~phase;
  assign inc_pc = inc_man | (auto_inc & phase);
  assign rom_data = ovr_en ? ovr : rom[rom_addr];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h4A;
    rom[12'h001] = 8'h5B;
    rom[12'h002] = 8'h6C;
    rom[12'h003] = 8'h77;
    rom[12'h004] = 8'hD4;
    rom[12'h005] = 8'hE5;
    rom[12'h7FE] = 8'h83;
    rom[12'h321] = 8'h9F;
    rom[12'hFFF] = 8'hA0;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h4A, 12'h001};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5B, 12'h002};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h6C, 12'h003};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h77, 12'h003};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hFE, 8'h77, 12'h7FE};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h21, 8'h83, 12'h321};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h9F, 12'h321};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h9F, 12'hFFF};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA0, 12'h000};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h4A, 12'h001};
    #1;
    chk("rst_pc", pc, 12'h000);
    chk("rst_ir", {instr, oprnd}, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_phase_en", phase_en, 1'b1);
    @(negedge clk2);
    reset2 = 1'b0;
    cur_pc = 12'h000;
    for (int i = 0; i < 10; i++) begin
      chk("tbl_phase_fetch", phase, 1'b0);
      @(negedge clk2);
      chk("tbl_ir", {instr, oprnd}, tbl[i].exp_ir);
      chk("tbl_pc_fetch", pc, cur_pc);
      inc_man = tbl[i].inc;
      load_pc = tbl[i].load;
      ovr_en = tbl[i].use_ovr;
      ovr = tbl[i].ovr_byte;
      @(negedge clk2);
      inc_man = 1'b0;
      load_pc = 1'b0;
      ovr_en = 1'b0;
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_rom_addr", rom_addr, tbl[i].exp_pc);
      cur_pc = tbl[i].exp_pc;
    end
    @(posedge clk2);
    #2 reset2 = 1'b1;
    #1;
    chk("midrst_pc", pc, 12'h000);
    chk("midrst_ir", {instr, oprnd}, 8'h00);
    chk("midrst_halted", halted, 1'b0);
    chk("midrst_phase_en", phase_en, 1'b1);
    chk("midrst_phase", phase, 1'b0);
    @(negedge clk2);
    reset2 = 1'b0;
    halt_req = 1'b1;
    @(negedge clk2);
    halt_req = 1'b0;
    chk("hreq_fetch_not_halted", halted, 1'b0);
    inc_man = 1'b1;
    @(negedge clk2);
    chk("halt_halted", halted, 1'b1);
    chk("halt_phase_en", phase_en, 1'b0);
    chk("halt_phase", phase, 1'b0);
    chk("halt_pc", pc, 12'h001);
    chk("halt_ir", {instr, oprnd}, 8'h4A);
    load_pc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk2);
      chk("frozen_pc", pc, 12'h001);
      chk("frozen_ir", {instr, oprnd}, 8'h4A);
      chk("frozen_phase", phase, 1'b0);
    end
    load_pc = 1'b0;
    inc_man = 1'b0;
    step_req = 1'b1;
    @(negedge clk2);
    step_req = 1'b0;
    chk("step_halted", halted, 1'b0);
    chk("step_phase_en", phase_en, 1'b1);
    @(negedge clk2);
    chk("step_ir", {instr, oprnd}, 8'h5B);
    inc_man = 1'b1;
    halt_req = 1'b1;
    @(negedge clk2);
    inc_man = 1'b0;
    halt_req = 1'b0;
    chk("step_done_halted", halted, 1'b1);
    chk("step_done_pc", pc, 12'h002);
    @(negedge clk2);
    chk("step_stays_halted", halted, 1'b1);
    chk("step_stays_pc", pc, 12'h002);
    run_req = 1'b1;
    step_req = 1'b1;
    @(negedge clk2);
    run_req = 1'b0;
    step_req = 1'b0;
    chk("runstep_halted", halted, 1'b0);
    chk("runstep_phase_en", phase_en, 1'b1);
    @(negedge clk2);
    chk("runstep_ir", {instr, oprnd}, 8'h6C);
    inc_man = 1'b1;
    @(negedge clk2);
    inc_man = 1'b0;
    chk("runstep_still_running", halted, 1'b0);
    chk("runstep_pc", pc, 12'h003);
    @(negedge clk2);
    halt_req = 1'b1;
    @(negedge clk2);
    halt_req = 1'b0;
    chk("hreq_exec_halted", halted, 1'b1);
    chk("hreq_exec_pc", pc, 12'h003);
    @(posedge clk2);
    #2 reset2 = 1'b1;
    #1;
    chk("haltrst_halted", halted, 1'b0);
    chk("haltrst_phase_en", phase_en, 1'b1);
    chk("haltrst_pc", pc, 12'h000);
    @(negedge clk2);
    reset2 = 1'b0;
`ifdef FETCH_BKPT_EN
    bkpt_addr = 12'h005;
    auto_inc = 1'b1;
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk2);
    chk("bkpt_halted", halted, 1'b1);
    chk("bkpt_pc", pc, 12'h005);
    chk("bkpt_ir", {instr, oprnd}, 8'hD4);
    chk("bkpt_hit", dut.bkpt_hit, 1'b1);
    run_req = 1'b1;
    @(negedge clk2);
    run_req = 1'b0;
    chk("bkpt_resume_halted", halted, 1'b0);
    chk("bkpt_hit_clear", dut.bkpt_hit, 1'b0);
    @(negedge clk2);
    chk("bkpt_resume_ir", {instr, oprnd}, 8'hE5);
    @(negedge clk2);
    chk("bkpt_resume_pc", pc, 12'h006);
    chk("bkpt_resume_running", halted, 1'b0);
    auto_inc = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
